// File: rtl/fir_xifu_ctrl.sv
// Per-ID issue/commit/kill tracking for the FIR X-interface coprocessor.
// Each XIF instruction ID runs a small lifecycle FSM; a registered counter bounds in-flight IDs.
module fir_xifu_ctrl #(
  parameter int NB_ID           = 16,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDW            = $clog2(NB_ID),
  localparam int CW             = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic [IDW-1:0]    issue_id_i,
  input  logic              issue_accept_i,
  output logic              issue_ready_o,
  input  logic              commit_valid_i,
  input  logic [IDW-1:0]    commit_id_i,
  input  logic              commit_kill_i,
  input  logic [NB_ID-1:0]  clear_i,
  input  logic              pipe_ready_i,
  output logic [NB_ID-1:0]  issue_o,
  output logic [NB_ID-1:0]  commit_o,
  output logic [NB_ID-1:0]  kill_o,
  output logic [CW-1:0]     outstanding_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_FREE      = 2'd0,
    S_ISSUED    = 2'd1,
    S_COMMITTED = 2'd2,
    S_KILLED    = 2'd3
  } state_e;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  state_e        state_q [NB_ID];
  state_e        state_d [NB_ID];
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic          err_q, err_d;
  logic          issue_fire;

  // Handshake: an issue transfers when issue_valid_i && issue_ready_o; issue_ready_o never
  // looks at issue_valid_i. issue_accept_i only decides whether a transferred issue claims its ID.
  assign issue_ready_o = pipe_ready_i & (outstanding_q < MAX_CNT);
  assign issue_fire    = issue_valid_i & issue_ready_o & issue_accept_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin : state_reg
    if (!rst_ni) begin
      for (int k = 0; k < NB_ID; k++) state_q[k] <= S_FREE;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      for (int k = 0; k < NB_ID; k++) state_q[k] <= state_d[k];
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  // Same-cycle order per ID: free (KILLED tick or clear, unless killed now), then issue, then commit.
  always_comb begin : next_state
    logic          iss_k;
    logic          cmt_k;
    logic          frees;
    logic          iss_ok;
    logic [CW-1:0] dec_cnt;
    state_e        s;
    iss_k   = 1'b0;
    cmt_k   = 1'b0;
    frees   = 1'b0;
    iss_ok  = 1'b0;
    dec_cnt = '0;
    s       = S_FREE;
    err_d   = err_q;
    for (int k = 0; k < NB_ID; k++) begin
      iss_k = issue_fire && (issue_id_i == IDW'(k));
      cmt_k = commit_valid_i && (commit_id_i == IDW'(k));
      frees = (state_q[k] == S_KILLED) ||
              ((state_q[k] == S_COMMITTED) && clear_i[k] && !(cmt_k && commit_kill_i));
      if (clear_i[k] && (state_q[k] != S_COMMITTED)) err_d = 1'b1;
      s = frees ? S_FREE : state_q[k];
      if (frees) dec_cnt = dec_cnt + CW'(1);
      if (iss_k) begin
        if (s == S_FREE) begin
          s      = S_ISSUED;
          iss_ok = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      if (cmt_k) begin
        if ((s == S_FREE) || (s == S_KILLED)) err_d = 1'b1;
        else if (commit_kill_i)               s = S_KILLED;
        else                                  s = S_COMMITTED;
      end
      state_d[k] = s;
    end
    outstanding_d = outstanding_q + CW'(iss_ok) - dec_cnt;
  end

  always_comb begin : output_decode
    issue_o  = '0;
    commit_o = '0;
    kill_o   = '0;
    for (int k = 0; k < NB_ID; k++) begin
      issue_o[k]  = (state_q[k] != S_FREE);
      commit_o[k] = (state_q[k] == S_COMMITTED);
      kill_o[k]   = (state_q[k] == S_KILLED);
    end
  end

  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Directed bench for fir_xifu_ctrl: inputs change on the falling edge, registered outputs
// are checked on the following falling edge, after the rising edge that consumed them.
module tb_fir_xifu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [3:0]  issue_id;
  logic        issue_accept;
  logic        issue_ready;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic [15:0] clear;
  logic        pipe_ready;
  logic [15:0] issue_vec;
  logic [15:0] commit_vec;
  logic [15:0] kill_vec;
  logic [2:0]  outstanding;
  logic        err;

  int checks   = 0;
  int failures = 0;

  fir_xifu_ctrl #(.NB_ID(16), .MAX_OUTSTANDING(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_id_i     (issue_id),
    .issue_accept_i (issue_accept),
    .issue_ready_o  (issue_ready),
    .commit_valid_i (commit_valid),
    .commit_id_i    (commit_id),
    .commit_kill_i  (commit_kill),
    .clear_i        (clear),
    .pipe_ready_i   (pipe_ready),
    .issue_o        (issue_vec),
    .commit_o       (commit_vec),
    .kill_o         (kill_vec),
    .outstanding_o  (outstanding),
    .err_o          (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_idle();
    issue_valid  = 1'b0;
    issue_id     = 4'd0;
    issue_accept = 1'b0;
    commit_valid = 1'b0;
    commit_id    = 4'd0;
    commit_kill  = 1'b0;
    clear        = 16'h0;
    pipe_ready   = 1'b1;
  endtask

  task automatic drive_issue(input logic [3:0] id, input logic acc);
    issue_valid  = 1'b1;
    issue_id     = id;
    issue_accept = acc;
  endtask

  task automatic drive_commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (issue_vec !== 16'h0)   begin failures++; $display("FAIL rst_issue: got %h expected 0000", issue_vec); end
    if (commit_vec !== 16'h0)  begin failures++; $display("FAIL rst_commit: got %h expected 0000", commit_vec); end
    if (kill_vec !== 16'h0)    begin failures++; $display("FAIL rst_kill: got %h expected 0000", kill_vec); end
    if (outstanding !== 3'd0)  begin failures++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
    if (err !== 1'b0)          begin failures++; $display("FAIL rst_err: got %b expected 0", err); end
    if (issue_ready !== 1'b1)  begin failures++; $display("FAIL rst_ready_hi: got %b expected 1", issue_ready); end
    pipe_ready = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b0)  begin failures++; $display("FAIL rst_ready_lo: got %b expected 0", issue_ready); end
    pipe_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reject();
    @(negedge clk);
    drive_issue(4'd1, 1'b0);
    @(negedge clk);
    drive_idle();
    checks += 3;
    if (issue_vec !== 16'h0)  begin failures++; $display("FAIL rej_issue: got %h expected 0000", issue_vec); end
    if (outstanding !== 3'd0) begin failures++; $display("FAIL rej_outstanding: got %0d expected 0", outstanding); end
    if (err !== 1'b0)         begin failures++; $display("FAIL rej_err: got %b expected 0", err); end
  endtask

  task automatic test_lifecycle();
    @(negedge clk);
    drive_issue(4'd3, 1'b1);
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin failures++; $display("FAIL lc_ready: got %b expected 1", issue_ready); end
    @(negedge clk);
    checks += 3;
    if (issue_vec !== 16'h0008)  begin failures++; $display("FAIL lc_issue_c1: got %h expected 0008", issue_vec); end
    if (commit_vec !== 16'h0000) begin failures++; $display("FAIL lc_commit_c1: got %h expected 0000", commit_vec); end
    if (outstanding !== 3'd1)    begin failures++; $display("FAIL lc_outstanding_c1: got %0d expected 1", outstanding); end
    drive_idle();
    drive_commit(4'd3, 1'b0);
    @(negedge clk);
    checks += 2;
    if (commit_vec !== 16'h0008) begin failures++; $display("FAIL lc_commit_c2: got %h expected 0008", commit_vec); end
    if (issue_vec !== 16'h0008)  begin failures++; $display("FAIL lc_issue_c2: got %h expected 0008", issue_vec); end
    drive_idle();
    @(negedge clk);
    clear = 16'h0008;
    @(negedge clk);
    drive_idle();
    checks += 4;
    if (issue_vec !== 16'h0)  begin failures++; $display("FAIL lc_issue_end: got %h expected 0000", issue_vec); end
    if (commit_vec !== 16'h0) begin failures++; $display("FAIL lc_commit_end: got %h expected 0000", commit_vec); end
    if (outstanding !== 3'd0) begin failures++; $display("FAIL lc_outstanding_end: got %0d expected 0", outstanding); end
    if (err !== 1'b0)         begin failures++; $display("FAIL lc_err: got %b expected 0", err); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_issue(4'(i), 1'b1);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks += 2;
    if (outstanding !== 3'd4) begin failures++; $display("FAIL bp_outstanding_full: got %0d expected 4", outstanding); end
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full: got %b expected 0", issue_ready); end
    drive_issue(4'd4, 1'b1);
    @(negedge clk);
    drive_idle();
    checks += 3;
    if (issue_vec !== 16'h000F) begin failures++; $display("FAIL bp_id4_blocked: got %h expected 000f", issue_vec); end
    if (outstanding !== 3'd4)   begin failures++; $display("FAIL bp_outstanding_hold: got %0d expected 4", outstanding); end
    if (err !== 1'b0)           begin failures++; $display("FAIL bp_err: got %b expected 0", err); end
    drive_commit(4'd0, 1'b0);
    @(negedge clk);
    drive_idle();
    clear = 16'h0001;
    @(negedge clk);
    drive_idle();
    #1;
    checks += 3;
    if (issue_ready !== 1'b1)   begin failures++; $display("FAIL bp_ready_back: got %b expected 1", issue_ready); end
    if (outstanding !== 3'd3)   begin failures++; $display("FAIL bp_outstanding_3: got %0d expected 3", outstanding); end
    if (issue_vec !== 16'h000E) begin failures++; $display("FAIL bp_issue_after_clear: got %h expected 000e", issue_vec); end
    for (int i = 1; i < 4; i++) begin
      drive_commit(4'(i), 1'b0);
      @(negedge clk);
    end
    drive_idle();
    clear = 16'h000E;
    @(negedge clk);
    drive_idle();
    checks += 2;
    if (outstanding !== 3'd0) begin failures++; $display("FAIL bp_drain: got %0d expected 0", outstanding); end
    if (err !== 1'b0)         begin failures++; $display("FAIL bp_drain_err: got %b expected 0", err); end
  endtask

  task automatic test_pipe_stall();
    @(negedge clk);
    pipe_ready = 1'b0;
    drive_issue(4'd6, 1'b1);
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b expected 0", issue_ready); end
    @(negedge clk);
    drive_idle();
    checks++;
    if (issue_vec !== 16'h0) begin failures++; $display("FAIL stall_issue: got %h expected 0000", issue_vec); end
  endtask

  task automatic test_kill();
    @(negedge clk);
    drive_issue(4'd5, 1'b1);
    @(negedge clk);
    drive_idle();
    checks++;
    if (issue_vec !== 16'h0020) begin failures++; $display("FAIL kill_issued: got %h expected 0020", issue_vec); end
    drive_commit(4'd5, 1'b1);
    @(negedge clk);
    drive_idle();
    checks += 3;
    if (kill_vec !== 16'h0020)  begin failures++; $display("FAIL kill_pulse: got %h expected 0020", kill_vec); end
    if (issue_vec !== 16'h0020) begin failures++; $display("FAIL kill_issue_hi: got %h expected 0020", issue_vec); end
    if (outstanding !== 3'd1)   begin failures++; $display("FAIL kill_outstanding_1: got %0d expected 1", outstanding); end
    @(negedge clk);
    checks += 4;
    if (kill_vec !== 16'h0)   begin failures++; $display("FAIL kill_pulse_end: got %h expected 0000", kill_vec); end
    if (issue_vec !== 16'h0)  begin failures++; $display("FAIL kill_freed: got %h expected 0000", issue_vec); end
    if (outstanding !== 3'd0) begin failures++; $display("FAIL kill_outstanding_0: got %0d expected 0", outstanding); end
    if (err !== 1'b0)         begin failures++; $display("FAIL kill_err: got %b expected 0", err); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    drive_issue(4'd2, 1'b1);
    @(negedge clk);
    drive_idle();
    drive_commit(4'd2, 1'b0);
    @(negedge clk);
    drive_idle();
    clear = 16'h0004;
    drive_issue(4'd2, 1'b1);
    @(negedge clk);
    drive_idle();
    checks += 4;
    if (issue_vec !== 16'h0004)  begin failures++; $display("FAIL same_clr_iss_issue: got %h expected 0004", issue_vec); end
    if (commit_vec !== 16'h0000) begin failures++; $display("FAIL same_clr_iss_commit: got %h expected 0000", commit_vec); end
    if (outstanding !== 3'd1)    begin failures++; $display("FAIL same_clr_iss_outstanding: got %0d expected 1", outstanding); end
    if (err !== 1'b0)            begin failures++; $display("FAIL same_clr_iss_err: got %b expected 0", err); end
    drive_commit(4'd2, 1'b0);
    @(negedge clk);
    drive_idle();
    clear = 16'h0004;
    @(negedge clk);
    drive_idle();
    drive_issue(4'd7, 1'b1);
    drive_commit(4'd7, 1'b0);
    @(negedge clk);
    drive_idle();
    checks += 4;
    if (commit_vec !== 16'h0080) begin failures++; $display("FAIL same_iss_cmt_commit: got %h expected 0080", commit_vec); end
    if (issue_vec !== 16'h0080)  begin failures++; $display("FAIL same_iss_cmt_issue: got %h expected 0080", issue_vec); end
    if (outstanding !== 3'd1)    begin failures++; $display("FAIL same_iss_cmt_outstanding: got %0d expected 1", outstanding); end
    if (err !== 1'b0)            begin failures++; $display("FAIL same_iss_cmt_err: got %b expected 0", err); end
    clear = 16'h0080;
    @(negedge clk);
    drive_idle();
    checks++;
    if (outstanding !== 3'd0) begin failures++; $display("FAIL same_drain: got %0d expected 0", outstanding); end
  endtask

  task automatic test_error_and_reset();
    @(negedge clk);
    drive_commit(4'd9, 1'b0);
    @(negedge clk);
    drive_idle();
    checks += 2;
    if (err !== 1'b1)         begin failures++; $display("FAIL err_set: got %b expected 1", err); end
    if (outstanding !== 3'd0) begin failures++; $display("FAIL err_outstanding: got %0d expected 0", outstanding); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_issue(4'(i), 1'b1);
    end
    @(negedge clk);
    drive_idle();
    drive_commit(4'd1, 1'b0);
    @(negedge clk);
    drive_idle();
    checks += 3;
    if (err !== 1'b1)            begin failures++; $display("FAIL err_sticky: got %b expected 1", err); end
    if (outstanding !== 3'd3)    begin failures++; $display("FAIL err_outstanding_3: got %0d expected 3", outstanding); end
    if (commit_vec !== 16'h0002) begin failures++; $display("FAIL err_commit_1: got %h expected 0002", commit_vec); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (outstanding !== 3'd0) begin failures++; $display("FAIL mid_rst_outstanding: got %0d expected 0", outstanding); end
    if (err !== 1'b0)         begin failures++; $display("FAIL mid_rst_err: got %b expected 0", err); end
    if (issue_vec !== 16'h0)  begin failures++; $display("FAIL mid_rst_issue: got %h expected 0000", issue_vec); end
    if (commit_vec !== 16'h0) begin failures++; $display("FAIL mid_rst_commit: got %h expected 0000", commit_vec); end
    if (kill_vec !== 16'h0)   begin failures++; $display("FAIL mid_rst_kill: got %h expected 0000", kill_vec); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_issue(4'd4, 1'b1);
    @(negedge clk);
    drive_idle();
    checks += 3;
    if (issue_vec !== 16'h0010) begin failures++; $display("FAIL post_rst_issue: got %h expected 0010", issue_vec); end
    if (outstanding !== 3'd1)   begin failures++; $display("FAIL post_rst_outstanding: got %0d expected 1", outstanding); end
    if (kill_vec !== 16'h0)     begin failures++; $display("FAIL post_rst_kill: got %h expected 0000", kill_vec); end
  endtask

  initial begin
    test_reset();
    test_reject();
    test_lifecycle();
    test_backpressure();
    test_pipe_stall();
    test_kill();
    test_same_cycle();
    test_error_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
